sram_1w1r_param: RTL and testbench

SRAM_1W1R_PARAM -- requirements
Module: sram_1w1r_param

---
 rtl/sram_1w1r_param.sv | 128 ++++++++++++
 tb/tb_sram_1w1r_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_1w1r_param.sv
// Parameterised 1-write/1-read SRAM with per-lane write mask, 1- or 2-cycle read latency and collision tracking.
// Optional macro SRAM_BYPASS_EN: a same-address read returns the merged (post-write) word instead of the old word.
module sram_1w1r_param #(
    parameter int unsigned DATA_WIDTH   = 240,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_WMASKS   = 30,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_vld,
    output logic                  coll,
    output logic [7:0]            coll_cnt
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned LANE_W = DATA_WIDTH / NUM_WMASKS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  coll_c;
    logic [DATA_WIDTH-1:0] bit_mask_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  pipe_vld_c;
    logic [DATA_WIDTH-1:0] pipe_data_c;

    logic [DATA_WIDTH-1:0] dout1_q,    dout1_d;
    logic                  dout1_vld_q;
    logic                  coll_q;
    logic [7:0]            coll_cnt_q, coll_cnt_d;

    assign wr_en_c = ~csb0;
    assign rd_en_c = ~csb1;
    assign coll_c  = wr_en_c && rd_en_c && (addr0 == addr1);

    // Expand lane enables into a bit mask and build the merged word for the write address.
    always_comb begin
        bit_mask_c = '0;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            bit_mask_c[i*LANE_W +: LANE_W] = {LANE_W{wmask0[i]}};
        end
        wr_word_c = (mem_q[addr0] & ~bit_mask_c) | (din0 & bit_mask_c);
    end

    // Colliding read sees either the merged word or the array contents from before this edge.
    always_comb begin
        rd_word_c = mem_q[addr1];
`ifdef SRAM_BYPASS_EN
        if (coll_c) begin
            rd_word_c = wr_word_c;
        end
`endif
    end

    // Array storage is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk0) begin
        if (wr_en_c) begin
            mem_q[addr0] <= wr_word_c;
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  s1_vld_q;
            logic [DATA_WIDTH-1:0] s1_data_q;

            always_ff @(posedge clk0 or posedge rst) begin
                if (rst) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q <= rd_en_c;
                    if (rd_en_c) begin
                        s1_data_q <= rd_word_c;
                    end
                end
            end

            assign pipe_vld_c  = s1_vld_q;
            assign pipe_data_c = s1_data_q;
        end else begin : g_lat1
            assign pipe_vld_c  = rd_en_c;
            assign pipe_data_c = rd_word_c;
        end
    endgenerate

    // Output data only moves on a new result so it never returns to X between reads.
    always_comb begin
        dout1_d    = dout1_q;
        coll_cnt_d = coll_cnt_q;
        if (pipe_vld_c) begin
            dout1_d = pipe_data_c;
        end
        if (coll_c && (coll_cnt_q != 8'hFF)) begin
            coll_cnt_d = coll_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            dout1_q     <= '0;
            dout1_vld_q <= 1'b0;
            coll_q      <= 1'b0;
            coll_cnt_q  <= 8'd0;
        end else begin
            dout1_q     <= dout1_d;
            dout1_vld_q <= pipe_vld_c;
            coll_q      <= coll_c;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    assign dout1     = dout1_q;
    assign dout1_vld = dout1_vld_q;
    assign coll      = coll_q;
    assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Scoreboard bench for sram_1w1r_param: one instance at read latency 1 and one at latency 2 share the same stimulus.
module tb_sram_1w1r_param;

    localparam int unsigned DW = 240;
    localparam int unsigned AW = 5;
    localparam int unsigned NM = 30;

    localparam logic [DW-1:0] A5W  = {30{8'hA5}};
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] L0Z  = {{232{1'b1}}, 8'h00};
`ifdef SRAM_BYPASS_EN
    localparam logic [DW-1:0] COLL1 = 240'h1;
    localparam logic [DW-1:0] COLL2 = 240'hFF01;
`else
    localparam logic [DW-1:0] COLL1 = 240'h0;
    localparam logic [DW-1:0] COLL2 = 240'h1;
`endif

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk0;
    logic          rst;
    logic          csb0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [NM-1:0] wmask0;
    logic          csb1;
    logic [AW-1:0] addr1;

    logic [DW-1:0] dout_w [2];
    logic          vld_w  [2];
    logic          coll_w [2];
    logic [7:0]    cnt_w  [2];

    exp_t        rq [2][$];
    int unsigned cq [$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    sram_1w1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .READ_LATENCY(1)) dut_l1 (
        .clk0(clk0), .rst(rst), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_w[0]), .dout1_vld(vld_w[0]),
        .coll(coll_w[0]), .coll_cnt(cnt_w[0])
    );

    sram_1w1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .READ_LATENCY(2)) dut_l2 (
        .clk0(clk0), .rst(rst), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_w[1]), .dout1_vld(vld_w[1]),
        .coll(coll_w[1]), .coll_cnt(cnt_w[1])
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Drive one cycle of stimulus and record what each instance should return for it.
    task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NM-1:0] wm, input logic r, input logic [AW-1:0] ra,
                      input logic [DW-1:0] rexp);
        exp_t e;
        csb0   = ~w;
        addr0  = wa;
        din0   = wd;
        wmask0 = wm;
        csb1   = ~r;
        addr1  = ra;
        if (r) begin
            e.data = rexp;
            e.cyc  = cyc + 1;
            rq[0].push_back(e);
            e.cyc  = cyc + 2;
            rq[1].push_back(e);
        end
        if (w && r && (wa == ra)) begin
            cq.push_back(cyc + 1);
        end
        @(negedge clk0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            op(1'b0, '0, '0, '0, 1'b0, '0, '0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_dout_l%0d", tag, p + 1), dout_w[p], '0);
            chk($sformatf("%s_vld_l%0d", tag, p + 1), DW'(vld_w[p]), '0);
            chk($sformatf("%s_coll_l%0d", tag, p + 1), DW'(coll_w[p]), '0);
            chk($sformatf("%s_cnt_l%0d", tag, p + 1), DW'(cnt_w[p]), '0);
        end
    endtask

    // Monitor: compares read results and collision pulses against the queued expectations.
    always @(negedge clk0) begin
        logic hit;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            while (rq[p].size() > 0 && rq[p][0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL rd_missed_l%0d due_cyc=%0d now=%0d", p + 1, rq[p][0].cyc, cyc);
                void'(rq[p].pop_front());
            end
            hit = (rq[p].size() > 0) && (rq[p][0].cyc == cyc);
            if (hit || vld_w[p] !== 1'b0) begin
                total++;
                e.data = '0;
                if (hit) e = rq[p].pop_front();
                if (vld_w[p] !== hit || (hit && dout_w[p] !== e.data)) begin
                    bad++;
                    $display("FAIL rd_l%0d cyc=%0d got vld=%b data=%h want vld=%b data=%h",
                             p + 1, cyc, vld_w[p], dout_w[p], hit, e.data);
                end
            end
        end
        while (cq.size() > 0 && cq[0] < cyc) begin
            void'(cq.pop_front());
        end
        hit = (cq.size() > 0) && (cq[0] == cyc);
        if (hit || coll_w[0] !== 1'b0 || coll_w[1] !== 1'b0) begin
            total++;
            if (hit) void'(cq.pop_front());
            if (coll_w[0] !== hit || coll_w[1] !== hit) begin
                bad++;
                $display("FAIL coll cyc=%0d got l1=%b l2=%b want=%b", cyc, coll_w[0], coll_w[1], hit);
            end
        end
    end

    initial begin
        rst = 1'b0;
        csb0 = 1'b1; csb1 = 1'b1; addr0 = '0; addr1 = '0; din0 = '0; wmask0 = '0;
        #2 rst = 1'b1;
        #1 chk_reset_state("por");
        repeat (2) @(negedge clk0);
        rst = 1'b0;

        // Write on the very first edge after release, then read it back.
        op(1'b1, 5'd3, A5W, '1, 1'b0, '0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 5'd3, A5W);

        // Partial mask: clear only lane 0 of an all-ones word.
        op(1'b1, 5'd7, ONES, '1, 1'b0, '0, '0);
        op(1'b1, 5'd7, '0, NM'(1), 1'b0, '0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 5'd7, L0Z);

        // Collisions: full-word and single-lane writes against a same-address read.
        op(1'b1, 5'd2, '0, '1, 1'b0, '0, '0);
        op(1'b1, 5'd2, 240'h1, '1, 1'b1, 5'd2, COLL1);
        op(1'b0, '0, '0, '0, 1'b1, 5'd2, 240'h1);
        op(1'b1, 5'd2, ONES, NM'(2), 1'b1, 5'd2, COLL2);
        op(1'b1, 5'd4, ONES, '1, 1'b1, 5'd3, A5W);
        op(1'b0, '0, '0, '0, 1'b1, 5'd2, 240'hFF01);
        idle(2);
        chk("cnt_two_l1", DW'(cnt_w[0]), DW'(8'd2));
        chk("cnt_two_l2", DW'(cnt_w[1]), DW'(8'd2));

        // Back-to-back reads stream out one per cycle, in order.
        op(1'b1, 5'd0, 240'h10, '1, 1'b0, '0, '0);
        op(1'b1, 5'd1, 240'h11, '1, 1'b0, '0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 5'd0, 240'h10);
        op(1'b0, '0, '0, '0, 1'b1, 5'd1, 240'h11);
        op(1'b0, '0, '0, '0, 1'b1, 5'd2, 240'hFF01);
        op(1'b0, '0, '0, '0, 1'b1, 5'd4, ONES);
        idle(3);

        // Zero-mask collisions still count and leave the word untouched; counter saturates.
        for (int i = 0; i < 300; i++) begin
            op(1'b1, 5'd3, ONES, '0, 1'b1, 5'd3, A5W);
        end
        idle(3);
        chk("cnt_sat_l1", DW'(cnt_w[0]), DW'(8'd255));
        chk("cnt_sat_l2", DW'(cnt_w[1]), DW'(8'd255));

        // Reset lands while a read is in flight; it must never surface.
        csb1  = 1'b0;
        addr1 = 5'd7;
        @(posedge clk0);
        #1 rst = 1'b1;
        csb1 = 1'b1;
        #1 chk_reset_state("midrd");
        repeat (2) @(negedge clk0);
        rst = 1'b0;
        op(1'b1, 5'd5, 240'h55, '1, 1'b1, 5'd7, L0Z);
        op(1'b0, '0, '0, '0, 1'b1, 5'd5, 240'h55);
        op(1'b0, '0, '0, '0, 1'b1, 5'd3, A5W);
        idle(4);

        chk("drain_l1", DW'(rq[0].size()), '0);
        chk("drain_l2", DW'(rq[1].size()), '0);
        chk("drain_coll", DW'(cq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
